// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters,
// combinational misprediction detect and saturating resolution statistics.
module branch_predictor #(
   parameter int INDEX_BITS = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] fetch_pc,
   output logic        predict_taken,
   output logic [15:0] predict_target,
   input  logic        update_valid,
   input  logic [15:0] update_pc,
   input  logic        update_taken,
   input  logic [15:0] update_target,
   input  logic        update_pred_taken,
   input  logic [15:0] update_pred_target,
   output logic        mispredict,
   input  logic        stats_clear,
   output logic [15:0] branch_count,
   output logic [15:0] mispredict_count
);

   localparam int ENTRIES  = 1 << INDEX_BITS;
   localparam int TAG_BITS = 15 - INDEX_BITS;

   localparam logic [1:0] CTR_STRONG_NT = 2'b00;
   localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
   localparam logic [1:0] CTR_WEAK_T    = 2'b10;
   localparam logic [1:0] CTR_STRONG_T  = 2'b11;

   // Single-cycle update interface: update_valid qualifies all update_* fields
   // for exactly the cycle it is high; there is no back-pressure.

   logic [ENTRIES-1:0]  valid_q;
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [15:0]         target_q [ENTRIES];
   logic [1:0]          ctr_q    [ENTRIES];

   logic [INDEX_BITS-1:0] fetch_idx;
   logic [TAG_BITS-1:0]   fetch_tag;
   logic [INDEX_BITS-1:0] upd_idx;
   logic [TAG_BITS-1:0]   upd_tag;
   logic                  fetch_hit;
   logic                  upd_hit;
   logic                  wrong_dir;
   logic                  wrong_tgt;
   logic                  pc_lsb_unused;

   assign fetch_idx = fetch_pc[INDEX_BITS:1];
   assign fetch_tag = fetch_pc[15:INDEX_BITS+1];
   assign upd_idx   = update_pc[INDEX_BITS:1];
   assign upd_tag   = update_pc[15:INDEX_BITS+1];

   // Instructions are halfword aligned; bit 0 never selects an entry.
   assign pc_lsb_unused = ^{fetch_pc[0], update_pc[0]};

   // Lookup sees pre-update contents: no bypass from the update port.
   assign fetch_hit      = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
   assign predict_taken  = reset_n && fetch_hit && ctr_q[fetch_idx][1];
   assign predict_target = target_q[fetch_idx];

   assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
   assign wrong_dir = update_taken != update_pred_taken;
   assign wrong_tgt = update_taken && (update_target != update_pred_target);
   assign mispredict = reset_n && update_valid && (wrong_dir || wrong_tgt);

   function automatic logic [1:0] sat_inc(input logic [1:0] c);
      return (c == CTR_STRONG_T) ? CTR_STRONG_T : c + 2'd1;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] c);
      return (c == CTR_STRONG_NT) ? CTR_STRONG_NT : c - 2'd1;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_WEAK_NT;
         end
      end else if (update_valid) begin
         if (upd_hit) begin
            if (update_taken) begin
               ctr_q[upd_idx]    <= sat_inc(ctr_q[upd_idx]);
               target_q[upd_idx] <= update_target;
            end else begin
               ctr_q[upd_idx] <= sat_dec(ctr_q[upd_idx]);
            end
         end else if (update_taken) begin
            // Allocation evicts whatever aliases into this slot.
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= update_target;
            ctr_q[upd_idx]    <= CTR_WEAK_T;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else if (stats_clear) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else begin
         if (update_valid && (branch_count != 16'hFFFF))
            branch_count <= branch_count + 16'd1;
         if (mispredict && (mispredict_count != 16'hFFFF))
            mispredict_count <= mispredict_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, multi-cycle corner
// sequences and random traffic checked against an array-based reference model.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] fetch_pc;
   logic        predict_taken;
   logic [15:0] predict_target;
   logic        update_valid;
   logic [15:0] update_pc;
   logic        update_taken;
   logic [15:0] update_target;
   logic        update_pred_taken;
   logic [15:0] update_pred_target;
   logic        mispredict;
   logic        stats_clear;
   logic [15:0] branch_count;
   logic [15:0] mispredict_count;

   int total = 0;
   int bad   = 0;

   branch_predictor dut (
      .clk(clk), .reset_n(reset_n), .fetch_pc(fetch_pc),
      .predict_taken(predict_taken), .predict_target(predict_target),
      .update_valid(update_valid), .update_pc(update_pc),
      .update_taken(update_taken), .update_target(update_target),
      .update_pred_taken(update_pred_taken), .update_pred_target(update_pred_target),
      .mispredict(mispredict), .stats_clear(stats_clear),
      .branch_count(branch_count), .mispredict_count(mispredict_count)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   // reference model: 16 entries, plain integer state
   bit          m_valid  [16];
   int          m_tag    [16];
   int          m_ctr    [16];
   logic [15:0] m_target [16];
   int          m_bc, m_mc;

   logic [49:0] exp_q[$];

   function automatic int m_idx(input logic [15:0] pc);
      return (int'(pc) / 2) % 16;
   endfunction

   function automatic int m_tagof(input logic [15:0] pc);
      return int'(pc) / 32;
   endfunction

   function automatic bit m_hit(input logic [15:0] pc);
      return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
   endfunction

   function automatic bit m_mispredict();
      if (!update_valid) return 1'b0;
      if (update_taken != update_pred_taken) return 1'b1;
      return update_taken && (update_target != update_pred_target);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = 1; m_target[i] = '0;
      end
      m_bc = 0; m_mc = 0;
   endtask

   // Called right at a rising edge, with the inputs the DUT samples on it.
   task automatic model_update();
      int i;
      bit mp;
      if (!reset_n) return;
      i  = m_idx(update_pc);
      mp = m_mispredict();
      if (stats_clear) begin
         m_bc = 0; m_mc = 0;
      end else begin
         if (update_valid) m_bc = (m_bc + 1 > 65535) ? 65535 : m_bc + 1;
         if (mp)           m_mc = (m_mc + 1 > 65535) ? 65535 : m_mc + 1;
      end
      if (update_valid) begin
         if (m_hit(update_pc)) begin
            if (update_taken) begin
               m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
               m_target[i] = update_target;
            end else begin
               m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
            end
         end else if (update_taken) begin
            m_valid[i] = 1; m_tag[i] = m_tagof(update_pc);
            m_target[i] = update_target; m_ctr[i] = 2;
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [15:0] fpc, input logic uv, input logic [15:0] upc,
                        input logic ut, input logic [15:0] utgt, input logic upt,
                        input logic [15:0] uptgt, input logic clr);
      fetch_pc = fpc; update_valid = uv; update_pc = upc; update_taken = ut;
      update_target = utgt; update_pred_taken = upt; update_pred_target = uptgt;
      stats_clear = clr;
   endtask

   // Finish a cycle: let the edge land and keep the model in step with it.
   task automatic edge_and_model();
      @(posedge clk);
      model_update();
      #1;
   endtask

   // directed vectors
   typedef struct {
      logic [15:0] fpc;
      logic        uv;
      logic [15:0] upc;
      logic        ut;
      logic [15:0] utgt;
      logic        upt;
      logic [15:0] uptgt;
      logic        e_pt;
      logic [15:0] e_tgt;
      logic        e_mp;
   } vec_t;

   function automatic vec_t mk(input logic [15:0] fpc, input logic uv, input logic [15:0] upc,
                               input logic ut, input logic [15:0] utgt, input logic upt,
                               input logic [15:0] uptgt, input logic e_pt,
                               input logic [15:0] e_tgt, input logic e_mp);
      vec_t v;
      v.fpc = fpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.upt = upt;
      v.uptgt = uptgt; v.e_pt = e_pt; v.e_tgt = e_tgt; v.e_mp = e_mp;
      return v;
   endfunction

   vec_t vecs[23];

   initial begin
      logic [15:0] pcs[4];
      logic [49:0] e;
      bit          ept;

      vecs[0]  = mk(16'h3004, 1, 16'h3004, 1, 16'h3020, 0, 16'h0000, 0, 16'h0000, 1);
      vecs[1]  = mk(16'h3004, 1, 16'h3004, 1, 16'h3020, 1, 16'h3020, 1, 16'h3020, 0);
      vecs[2]  = mk(16'h3004, 1, 16'h3004, 0, 16'h0000, 1, 16'h3020, 1, 16'h3020, 1);
      vecs[3]  = mk(16'h3004, 1, 16'h3004, 0, 16'h0000, 1, 16'h3020, 1, 16'h3020, 1);
      vecs[4]  = mk(16'h3004, 1, 16'h3004, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
      vecs[5]  = mk(16'h3004, 1, 16'h3004, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
      vecs[6]  = mk(16'h3004, 1, 16'h3004, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
      vecs[7]  = mk(16'h3004, 1, 16'h3004, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
      vecs[8]  = mk(16'h3004, 1, 16'h3004, 1, 16'h3020, 0, 16'h0000, 0, 16'h0000, 1);
      vecs[9]  = mk(16'h3004, 1, 16'h3004, 1, 16'h3020, 0, 16'h0000, 0, 16'h0000, 1);
      vecs[10] = mk(16'h3004, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h3020, 0);
      vecs[11] = mk(16'h3004, 1, 16'h3004, 0, 16'h0000, 1, 16'h3020, 1, 16'h3020, 1);
      vecs[12] = mk(16'h3004, 1, 16'h3004, 1, 16'h3020, 0, 16'h0000, 0, 16'h0000, 1);
      vecs[13] = mk(16'h3004, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h3020, 0);
      vecs[14] = mk(16'h3004, 1, 16'h3024, 1, 16'h4000, 0, 16'h0000, 1, 16'h3020, 1);
      vecs[15] = mk(16'h3004, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
      vecs[16] = mk(16'h3024, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h4000, 0);
      vecs[17] = mk(16'h0000, 1, 16'h3024, 1, 16'h4100, 1, 16'h4000, 0, 16'h0000, 1);
      vecs[18] = mk(16'h3024, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h4100, 0);
      vecs[19] = mk(16'h3024, 1, 16'h3024, 0, 16'h1234, 0, 16'h5678, 1, 16'h4100, 0);
      vecs[20] = mk(16'h3025, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h4100, 0);
      vecs[21] = mk(16'h5000, 1, 16'h5000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
      vecs[22] = mk(16'h5000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);

      // reset with an update pending: nothing may be learned or counted
      reset_n = 1'b0;
      model_reset();
      drive(16'h3000, 1, 16'h3000, 1, 16'h3020, 0, 16'h0000, 0);
      repeat (2) begin
         @(negedge clk);
         check("rst_predict_taken", predict_taken, 0);
         check("rst_mispredict", mispredict, 0);
         check("rst_branch_count", branch_count, 0);
         check("rst_mispredict_count", mispredict_count, 0);
      end
      reset_n = 1'b1;
      update_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("post_rst_no_alloc", predict_taken, 0);
      check("post_rst_branch_count", branch_count, 0);
      @(posedge clk); #1;

      // directed table
      foreach (vecs[k]) begin
         drive(vecs[k].fpc, vecs[k].uv, vecs[k].upc, vecs[k].ut, vecs[k].utgt,
               vecs[k].upt, vecs[k].uptgt, 0);
         @(negedge clk);
         check($sformatf("vec%0d_predict_taken", k), predict_taken, vecs[k].e_pt);
         if (vecs[k].e_pt)
            check($sformatf("vec%0d_predict_target", k), predict_target, vecs[k].e_tgt);
         check($sformatf("vec%0d_mispredict", k), mispredict, vecs[k].e_mp);
         edge_and_model();
      end
      @(negedge clk);
      check("table_branch_count", branch_count, 16);
      check("table_mispredict_count", mispredict_count, 9);
      @(posedge clk); #1;

      // random traffic against the reference model
      pcs[0] = 16'h3000; pcs[1] = 16'h3020; pcs[2] = 16'h3040; pcs[3] = 16'h5000;
      for (int n = 0; n < 2000; n++) begin
         logic [15:0] upc;
         upc = pcs[$urandom_range(0, 3)] + 16'($urandom_range(0, 3) * 2) + 16'($urandom_range(0, 1));
         ept = m_hit(upc) && (m_ctr[m_idx(upc)] >= 2);
         if ($urandom_range(0, 1) == 1)
            drive(pcs[$urandom_range(0, 3)] + 16'($urandom_range(0, 3) * 2), ($urandom_range(0, 9) < 7),
                  upc, 1'($urandom_range(0, 1)), 16'h4000 + 16'($urandom_range(0, 3) * 2),
                  ept, m_target[m_idx(upc)], ($urandom_range(0, 63) == 0));
         else
            drive(upc, ($urandom_range(0, 9) < 7), upc, 1'($urandom_range(0, 1)),
                  16'h4000 + 16'($urandom_range(0, 3) * 2), 1'($urandom_range(0, 1)),
                  16'h4000 + 16'($urandom_range(0, 3) * 2), ($urandom_range(0, 63) == 0));
         ept = m_hit(fetch_pc) && (m_ctr[m_idx(fetch_pc)] >= 2);
         exp_q.push_back({ept, m_target[m_idx(fetch_pc)], m_mispredict(),
                          16'(m_bc), 16'(m_mc)});
         @(negedge clk);
         e = exp_q.pop_front();
         check("rnd_predict_taken", predict_taken, e[49]);
         if (e[49]) check("rnd_predict_target", predict_target, e[48:33]);
         check("rnd_mispredict", mispredict, e[32]);
         check("rnd_branch_count", branch_count, e[31:16]);
         check("rnd_mispredict_count", mispredict_count, e[15:0]);
         edge_and_model();
      end

      // asynchronous reset in the middle of traffic
      drive(16'h0000, 1, 16'h7002, 1, 16'h7100, 0, 16'h0000, 0);
      edge_and_model();
      drive(16'h7002, 1, 16'h7002, 0, 16'h0000, 1, 16'h7100, 0);
      @(negedge clk);
      check("midrst_pre_hit", predict_taken, 1);
      check("midrst_pre_mispredict", mispredict, 1);
      reset_n = 1'b0;
      model_reset();
      #1;
      check("midrst_async_predict", predict_taken, 0);
      check("midrst_async_mispredict", mispredict, 0);
      check("midrst_async_branch_count", branch_count, 0);
      @(posedge clk); #1;
      @(negedge clk);
      reset_n = 1'b1;
      update_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("midrst_entry_gone", predict_taken, 0);
      check("midrst_branch_count", branch_count, 0);
      @(posedge clk); #1;

      // saturation of branch_count
      drive(16'h0000, 1, 16'h5000, 0, 16'h0000, 0, 16'h0000, 0);
      repeat (65535) begin
         @(posedge clk);
         model_update();
      end
      #1;
      @(negedge clk);
      check("sat_branch_count_max", branch_count, 16'hFFFF);
      check("sat_mispredict_count", mispredict_count, 0);
      edge_and_model();
      @(negedge clk);
      check("sat_branch_count_hold", branch_count, 16'hFFFF);
      @(posedge clk); #1;

      // clear wins over simultaneous increments and leaves the BTB alone
      drive(16'h5000, 1, 16'h5000, 1, 16'h5100, 0, 16'h0000, 1);
      @(negedge clk);
      check("clr_mispredict_now", mispredict, 1);
      edge_and_model();
      drive(16'h5000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
      @(negedge clk);
      check("clr_branch_count", branch_count, 0);
      check("clr_mispredict_count", mispredict_count, 0);
      check("clr_btb_kept", predict_taken, 1);
      check("clr_btb_target", predict_target, 16'h5100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage direct-mapped branch target buffer with one 2-bit saturating counter per entry.
- Each cycle it supplies predict_taken and predict_target for the fetch PC.
- It is trained by the resolved branch outcome arriving from WB.
- It flags mispredictions combinationally so the flush/PC-select logic can redirect the pipeline, and keeps saturating branch and misprediction statistics counters.

Parameters:
- INDEX_BITS, 4, log2 of entry count (16 entries); index = pc[INDEX_BITS:1].
- TAG_BITS, 15-INDEX_BITS (derived, not overridable), tag = pc[15:INDEX_BITS+1].

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset_n  input  1  reset.
- fetch_pc  input  16  PC of the instruction being fetched.
- predict_taken  output  1  predict the fetched instruction is a taken branch.
- predict_target  output  16  predicted target; meaningful only when predict_taken=1.
- update_valid  input  1  a control-flow instruction resolved in WB this cycle.
- update_pc  input  16  PC of the resolving instruction.
- update_taken  input  1  actual outcome.
- update_target  input  16  actual target.
- update_pred_taken  input  1  prediction made at fetch, carried down the pipe.
- update_pred_target  input  16  predicted target carried down the pipe.
- mispredict  output  1  misprediction detected this cycle.
- stats_clear  input  1  synchronous clear of both statistics counters.
- branch_count  output  16  resolved branches, saturating.
- mispredict_count  output  16  mispredictions, saturating.

Behaviour:
- Reset (interface): one clock; reset is asynchronous and active-low (reset_n).
- Reset values:
  - All valid bits = 0, all counters = 2'b01 (weakly not-taken), tags/targets = 0.
  - branch_count = mispredict_count = 0.
  - predict_taken = 0 and mispredict = 0 while reset_n is low.
- Reset asserted mid-operation discards any in-flight update. No update occurs on the edge at which reset_n is low.
- Lookup (combinational, zero latency):
  - hit = valid[idx(fetch_pc)] && tag match.
  - predict_taken = hit && ctr[idx][1].
  - predict_target = target[idx] (don't-care when predict_taken=0).
- mispredict (combinational):
  - = update_valid && ((update_taken != update_pred_taken) || (update_taken && update_target != update_pred_target)).
  - Target comparison is ignored when update_taken=0.
- Update on rising edge when update_valid=1, with i = idx(update_pc):
  - Hit, taken: ctr = sat_inc(ctr), max 2'b11; target[i] = update_target.
  - Hit, not-taken: ctr = sat_dec(ctr), min 2'b00; target unchanged.
  - Miss, taken: allocate, replacing any occupant: valid=1, tag=update_pc tag, target=update_target, ctr=2'b10.
  - Miss, not-taken: no state change.
- Simultaneous lookup and update to the same index: lookup returns the pre-update contents. There is no write-through bypass; the new state is visible from the next cycle.
- update_pc and fetch_pc bit 0 are ignored.
- Statistics:
  - On update_valid, branch_count increments, saturating at 16'hFFFF.
  - On mispredict, mispredict_count increments, saturating at 16'hFFFF.
  - stats_clear=1 zeroes both on the edge and wins over a simultaneous increment.
  - stats_clear does not affect the BTB.
- Aliasing: two PCs with equal index and different tag evict each other. There is no associativity.

Test Plan:
1. Reset, then fetch_pc=16'h3000 → predict_taken=0. Release reset_n mid-stream with update_valid=1 → no entry allocated, branch_count=0.
2. Train allocate: update_pc=16'h3004, taken=1, target=16'h3020, pred_taken=0 → mispredict=1 that cycle. Next cycle, fetch_pc=16'h3004 → predict_taken=1, predict_target=16'h3020. Counts become 1/1.
3. Hysteresis on pc=16'h3004 (entry ctr=10):
   - Taken → 11. Not-taken → 10, predict still 1. Not-taken → 01, predict 0.
   - Three more not-taken → stays 00. Two taken → 10, predict 1.
4. Same-cycle hazard: fetch_pc = update_pc = 16'h3004, ctr=01, update taken → predict_taken=0 this cycle, 1 next cycle.
5. Alias/target change:
   - Entry at 16'h3004; update_pc=16'h3024 (same index, different tag), taken, target 16'h4000 → fetch 16'h3004 now misses (predict_taken=0).
   - Hit with taken=1, pred_taken=1, target≠pred_target → mispredict=1.
6. Stats:
   - Force branch_count to 16'hFFFF via 65535 updates, one more → stays 16'hFFFF.
   - stats_clear=1 with update_valid=1 and mispredict=1 → both counters 0 next cycle.
